// File: rtl/bpm_uart_reporter.sv
// Captures BPM results, converts them to three ASCII digits and sends "HTO\r\n" over UART 8N1.
// Optional BPM_AVG_EN: transmit the rounded mean of the last four captures instead of the raw value.
module bpm_uart_reporter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] bpm_value,
   input  logic       bpm_valid,
   output logic       bpm_copied,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, CONVERT, START, DATA, STOP} state_t;

   state_t             state_reg;
   logic [7:0]         value_reg;
   logic [3:0]         hund_reg;
   logic [3:0]         tens_reg;
   logic [3:0]         ones_reg;
   logic [2:0]         byte_reg;
   logic [2:0]         bit_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [7:0]         shift_reg;
   logic [7:0]         next_byte;
   logic [7:0]         capture_value;
   logic               capture;
   logic               bit_tick;

   assign capture  = (state_reg == IDLE) && en && bpm_valid;
   assign bit_tick = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

`ifdef BPM_AVG_EN
   logic [7:0] hist_reg [4];
   logic       hist_full_reg;
   logic [9:0] sum;

   // The new sample joins the three most recent entries; the oldest drops out.
   assign sum = 10'(bpm_value) + 10'(hist_reg[0]) + 10'(hist_reg[1]) + 10'(hist_reg[2]) + 10'd2;
   assign capture_value = hist_full_reg ? 8'(sum >> 2) : bpm_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_full_reg <= 1'b0;
         for (int i = 0; i < 4; i++) hist_reg[i] <= 8'd0;
      end else if (capture) begin
         hist_full_reg <= 1'b1;
         hist_reg[0]   <= bpm_value;
         for (int i = 1; i < 4; i++) hist_reg[i] <= hist_full_reg ? hist_reg[i-1] : bpm_value;
      end
   end
`else
   assign capture_value = bpm_value;
`endif

   // Byte that follows the one currently in flight.
   always_comb begin
      case (byte_reg)
         3'd0:    next_byte = {4'h3, tens_reg};
         3'd1:    next_byte = {4'h3, ones_reg};
         3'd2:    next_byte = 8'h0D;
         default: next_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         value_reg  <= 8'd0;
         hund_reg   <= 4'd0;
         tens_reg   <= 4'd0;
         ones_reg   <= 4'd0;
         byte_reg   <= 3'd0;
         bit_reg    <= 3'd0;
         cnt_reg    <= '0;
         shift_reg  <= 8'd0;
         bpm_copied <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         bpm_copied <= 1'b0;
         frame_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (capture) begin
                  value_reg  <= capture_value;
                  hund_reg   <= 4'd0;
                  tens_reg   <= 4'd0;
                  bpm_copied <= 1'b1;
                  busy       <= 1'b1;
                  state_reg  <= CONVERT;
               end
            end
            CONVERT: begin
               if (value_reg >= 8'd100) begin
                  value_reg <= value_reg - 8'd100;
                  hund_reg  <= hund_reg + 4'd1;
               end else if (value_reg >= 8'd10) begin
                  value_reg <= value_reg - 8'd10;
                  tens_reg  <= tens_reg + 4'd1;
               end else begin
                  ones_reg  <= value_reg[3:0];
                  shift_reg <= {4'h3, hund_reg};
                  byte_reg  <= 3'd0;
                  cnt_reg   <= '0;
                  tx        <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (bit_tick) begin
                  cnt_reg   <= '0;
                  bit_reg   <= 3'd0;
                  tx        <= shift_reg[0];
                  state_reg <= DATA;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  cnt_reg <= '0;
                  if (bit_reg == 3'd7) begin
                     tx        <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     bit_reg   <= bit_reg + 3'd1;
                     shift_reg <= shift_reg >> 1;
                     tx        <= shift_reg[1];
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  cnt_reg <= '0;
                  if (byte_reg == 3'd4) begin
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state_reg  <= IDLE;
                  end else begin
                     byte_reg  <= byte_reg + 3'd1;
                     shift_reg <= next_byte;
                     tx        <= 1'b0;
                     state_reg <= START;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bpm_uart_reporter.sv
// Bench for bpm_uart_reporter: frame-level reference model checked every cycle plus directed literal frames.
// Build with BPM_AVG_EN defined to exercise the averaging variant.
module tb_bpm_uart_reporter;
   localparam int CPB  = 4;
   localparam int FLEN = 50 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] bpm_value = 8'd0;
   logic       bpm_valid = 1'b0;
   logic       bpm_copied;
   logic       tx;
   logic       busy;
   logic       frame_done;

   always #5 clk = ~clk;

   bpm_uart_reporter #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .bpm_value(bpm_value), .bpm_valid(bpm_valid),
      .bpm_copied(bpm_copied), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: once a capture is known, the whole 50-bit frame is fixed by arithmetic.
   typedef enum int {P_IDLE, P_WAIT, P_TX, P_LOST} phase_t;
   phase_t      ph = P_IDLE;
   bit          cap_pending = 0;
   logic [7:0]  cap_val = 8'd0;
   logic        fbits [50];
   logic [49:0] rxbits;
   logic [39:0] last_rx = 40'd0;
   int          k = 0, wait_cnt = 0, frame_cnt = 0, mv = 0;
   int          fb [5];
   int          mh [4];
   bit          mh_full = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_tx", tx, 1);
         chk("rst_busy", busy, 0);
         chk("rst_copied", bpm_copied, 0);
         chk("rst_done", frame_done, 0);
         ph = P_IDLE;
         cap_pending = 0;
         mh_full = 0;
      end else begin
         chk("copied", bpm_copied, cap_pending);
         if (cap_pending) begin
            cap_pending = 0;
            mv = cap_val;
`ifdef BPM_AVG_EN
            if (!mh_full) begin
               for (int i = 0; i < 4; i++) mh[i] = cap_val;
               mh_full = 1;
            end else begin
               mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = cap_val;
            end
            mv = (mh[0] + mh[1] + mh[2] + mh[3] + 2) / 4;
`endif
            fb[0] = 48 + mv / 100;
            fb[1] = 48 + (mv / 10) % 10;
            fb[2] = 48 + mv % 10;
            fb[3] = 13;
            fb[4] = 10;
            for (int b = 0; b < 5; b++) begin
               fbits[b*10] = 1'b0;
               for (int i = 0; i < 8; i++) fbits[b*10+1+i] = fb[b][i];
               fbits[b*10+9] = 1'b1;
            end
            ph = P_WAIT;
            wait_cnt = 0;
         end
         if (ph == P_IDLE) begin
            chk("idle_busy", busy, 0);
            chk("idle_tx", tx, 1);
            chk("idle_done", frame_done, 0);
            cap_pending = en && bpm_valid;
            cap_val = bpm_value;
         end
         if (ph == P_WAIT) begin
            wait_cnt++;
            chk("conv_busy", busy, 1);
            chk("conv_done", frame_done, 0);
            if (tx === 1'b0) begin
               ph = P_TX;
               k = 0;
            end else if (wait_cnt >= 16) begin
               chk("start_by_16", tx, 0);
               ph = P_LOST;
            end
         end
         if (ph == P_TX) begin
            if (k < FLEN) begin
               chk("tx_bit", tx, fbits[k/CPB]);
               chk("tx_busy", busy, 1);
               chk("tx_done", frame_done, 0);
               if (k % CPB == CPB / 2) rxbits[k/CPB] = tx;
               k++;
            end else begin
               chk("frame_done", frame_done, 1);
               chk("end_busy", busy, 0);
               chk("end_tx", tx, 1);
               for (int b = 0; b < 5; b++)
                  for (int i = 0; i < 8; i++) last_rx[(4-b)*8+i] = rxbits[b*10+1+i];
               frame_cnt++;
               ph = P_IDLE;
               cap_pending = en && bpm_valid;
               cap_val = bpm_value;
            end
         end
         if (ph == P_LOST && busy === 1'b0) begin
            ph = P_IDLE;
            cap_pending = en && bpm_valid;
            cap_val = bpm_value;
         end
      end
   end

   int fexp = 0;

   task automatic wait_copied();
      int n = 0;
      while (bpm_copied !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("copied_seen", bpm_copied, 1);
      bpm_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] v);
      bpm_value = v;
      bpm_valid = 1'b1;
      wait_copied();
   endtask

   task automatic wait_frame(input int target);
      int n = 0;
      while (frame_cnt < target && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("frame_count", frame_cnt, target);
   endtask

   // Sends one value and measures capture-to-start latency and start-to-frame_done length.
   task automatic run_frame(input string name, input logic [7:0] v, input logic [39:0] exp);
      int lat = 0, len = 0, cp = 0;
      send(v);
      while (tx === 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (bpm_copied) cp++;
      end
      chk({name, "_start_latency_ok"}, (lat <= 16), 1);
      while (frame_done !== 1'b1 && len < 400) begin
         @(posedge clk); #1;
         len++;
         if (bpm_copied) cp++;
      end
      chk({name, "_frame_len"}, len, FLEN);
      chk({name, "_copied_extra"}, cp, 0);
      fexp++;
      wait_frame(fexp);
      chk({name, "_bytes"}, last_rx, exp);
      $display("frame %s: value %0d -> bytes 0x%010h", name, v, last_rx);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
`ifdef BPM_AVG_EN
      run_frame("avg1", 8'd60, 40'h30_36_30_0D_0A);
      run_frame("avg2", 8'd60, 40'h30_36_30_0D_0A);
      run_frame("avg3", 8'd60, 40'h30_36_30_0D_0A);
      run_frame("avg4", 8'd100, 40'h30_37_30_0D_0A);
`else
      run_frame("v72", 8'd72, 40'h30_37_32_0D_0A);
      run_frame("v0", 8'd0, 40'h30_30_30_0D_0A);
      run_frame("v255", 8'd255, 40'h32_35_35_0D_0A);
      run_frame("v199", 8'd199, 40'h31_39_39_0D_0A);

      // Second result raised mid-frame is held off until the frame ends.
      send(8'd45);
      repeat (30) @(posedge clk);
      #1;
      bpm_value = 8'd90;
      bpm_valid = 1'b1;
      fexp++;
      wait_frame(fexp);
      chk("mid_first_bytes", last_rx, 40'h30_34_35_0D_0A);
      $display("frame mid1: bytes 0x%010h", last_rx);
      wait_copied();
      fexp++;
      wait_frame(fexp);
      chk("mid_second_bytes", last_rx, 40'h30_39_30_0D_0A);
      $display("frame mid2: bytes 0x%010h", last_rx);
      repeat (300) @(posedge clk);
      #1;
      chk("no_duplicate", frame_cnt, fexp);

      // en low blocks capture; en high captures on the next edge; en low mid-frame is harmless.
      begin
         int cp = 0, lows = 0;
         en = 1'b0;
         bpm_value = 8'd99;
         bpm_valid = 1'b1;
         for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (bpm_copied) cp++;
            if (!tx) lows++;
         end
         chk("en_off_copied", cp, 0);
         chk("en_off_tx_low", lows, 0);
         en = 1'b1;
         @(posedge clk); #1;
         chk("en_capture", bpm_copied, 1);
         bpm_valid = 1'b0;
         repeat (60) @(posedge clk);
         #1;
         en = 1'b0;
         fexp++;
         wait_frame(fexp);
         chk("en_drop_bytes", last_rx, 40'h30_39_39_0D_0A);
         $display("frame en: bytes 0x%010h", last_rx);
         en = 1'b1;
      end

      // Reset during the third byte abandons the frame; the next one is clean.
      send(8'd123);
      repeat (100) @(posedge clk);
      #1;
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("async_tx", tx, 1);
      chk("async_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_frame("v60", 8'd60, 40'h30_36_30_0D_0A);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bpm_uart_reporter.md
Name: bpm_uart_reporter

Overview:
- Consumer end of the BPM result handshake (`bpm_value`/`bpm_valid`/`bpm_copied`).
- Captures each new 8-bit BPM result, acknowledges it with a one-cycle `bpm_copied` pulse, and converts it to three ASCII decimal digits.
- Sends the digits plus CR LF as a UART 8N1 frame on a single `tx` pin, for the debug/host link.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- en  input  1  capture enable; gates new captures only
- bpm_value  input  8  BPM result from the producer
- bpm_valid  input  1  producer holds high until it sees bpm_copied
- bpm_copied  output  1  one-cycle acknowledge, registered
- tx  output  1  UART serial out, idle high
- busy  output  1  high from capture until the end of the last stop bit
- frame_done  output  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset values: bpm_copied=0, tx=1, busy=0, frame_done=0, state=IDLE. All internal regs are cleared.
- Reset asserted mid-frame: tx returns high immediately (asynchronous). The partial frame is abandoned and never resumed.
- States: IDLE -> CONVERT -> START -> DATA -> STOP -> (next byte: START | done: IDLE).
- IDLE:
  - On en && bpm_valid at a clk edge: latch bpm_value, go to CONVERT, set busy=1.
  - bpm_copied=1 in the following cycle only; it is never high two consecutive cycles.
- CONVERT (binary to BCD by iterative subtraction, one subtraction per cycle):
  - Subtract 100 while value >= 100, then 10 while value >= 10; the remainder is the ones digit.
  - Max 2+9+1 cycles. The START bit must begin no later than 16 cycles after capture.
- Frame: exactly 5 bytes, in order 0x30+H, 0x30+T, 0x30+O, 0x0D, 0x0A. Leading zeros are sent (e.g. 7 -> "007").
- Byte timing:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back with no idle gap between stop and next start.
  - Frame length = 50*CLKS_PER_BIT cycles from the first start-bit edge.
- End of frame:
  - At the end of the last stop bit, busy falls and frame_done pulses for one cycle simultaneously; state returns to IDLE.
- bpm_valid while busy: ignored; the producer holds it. Capture happens on the first edge with state=IDLE, i.e. the cycle after frame_done, provided en=1.
- en deasserted mid-frame: no effect; the frame completes. en only blocks a capture from IDLE.
- bpm_valid and en rising in the same cycle from IDLE: capture occurs on that edge.
- bpm_value is sampled only at capture; later changes never affect the frame in flight.

Optional Feature:
- Macro: BPM_AVG_EN.
- Defined:
  - A 4-entry history of captured values is kept.
  - The transmitted value = (sum of the 4 entries + 2) >> 2; the sum is 10 bits wide.
  - The first capture after reset fills all 4 entries with that sample.
  - Averaging adds at most 1 cycle before CONVERT; the 16-cycle start bound still holds.
- Undefined: the raw captured value is transmitted and no history regs exist.

Test Plan:
- CLKS_PER_BIT=4, bpm_value=72 pulse-held valid -> bpm_copied high exactly 1 cycle; tx bytes 0x30,0x37,0x32,0x0D,0x0A; 200 cycles from first start edge to frame_done.
- Values 0 and 255 -> frames "000\r\n" and "255\r\n"; the start bit begins within 16 cycles of capture in both cases.
- Second bpm_valid (value 90) raised mid-frame -> no bpm_copied until the cycle after frame_done; then "090\r\n" is sent with no lost or duplicated frame.
- rst_n low during the 3rd byte -> tx=1, busy=0 asynchronously; after release, a new valid of 60 yields a clean "060\r\n".
- en=0 with bpm_valid high for 500 cycles -> tx stays 1, bpm_copied stays 0. Raising en -> capture on the next edge. Dropping en mid-frame -> frame still completes.
- BPM_AVG_EN defined, captures 60,60,60,100 -> frames "060","060","060","070".
